// File: rtl/ysyx_24110015_lsu.sv
// ysyx_24110015_lsu -- multi-cycle load/store unit between execute and write-back.
//
// Takes one instruction at a time from execute (in_*) over a valid/ready
// handshake. For loads and stores it issues a single word-aligned request on
// the mem_req_* bus and waits for mem_resp_valid. It then hands the extended
// load data, the passed-through ALU/CSR result, or 0 for stores to write-back
// over the out_* handshake.
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   in_valid/in_ready             execute handshake (ready only while idle)
//   in_addr/wdata/func3/load/store/result   instruction fields, latched on accept
//   mem_req_valid/ready/addr/wen/wdata/wmask   memory request channel
//   mem_resp_valid/rdata          memory response (acknowledges reads and writes)
//   out_valid/ready/data/fault    write-back handshake
//
// Optional feature, selected by macro LSU_MISALIGN_CHECK_EN:
//   When defined, misaligned halfword/word accesses skip the memory and go
//   straight to write-back with out_fault=1 and out_data=address.
//   When undefined, out_fault is tied 0 and misaligned accesses are issued
//   as-is (truncated masks/data).
module ysyx_24110015_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [2:0]        in_func3,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [31:0]       in_result,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_fault
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [2:0]        func3;
    logic              load;
    logic              store;
  } lsu_req_t;

  state_t      state, state_nxt;
  lsu_req_t    req_q;
  logic [31:0] data_q;
  logic [1:0]  off;
  logic        accept;
  logic        is_mem;
  logic        fault_in;
  logic [3:0]  st_mask;
  logic [31:0] st_wdata;
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  assign accept = (state == IDLE) && in_valid;
  assign is_mem = in_load | in_store;
  assign off    = req_q.addr[1:0];

`ifdef LSU_MISALIGN_CHECK_EN
  // Halfword needs an even offset, word needs offset 0. Only memory ops fault.
  assign fault_in = is_mem &&
                    ((((in_func3 == 3'b001) || (in_func3 == 3'b101)) && in_addr[0]) ||
                     ((in_func3 == 3'b010) && (in_addr[1:0] != 2'b00)));
`else
  assign fault_in = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)       state_nxt = (is_mem && !fault_in) ? REQ : OUT;
      REQ:  if (mem_req_ready)  state_nxt = RESP;
      RESP: if (mem_resp_valid) state_nxt = OUT;
      OUT:  if (out_ready)      state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // ---------------- instruction latch ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        req_q <= '0;
    else if (accept) req_q <= '{addr: in_addr, wdata: in_wdata, func3: in_func3,
                                load: in_load, store: in_store};
  end

  // ---------------- store lane alignment ----------------
  // Shifting a 4-bit literal drops strobes that would fall past lane 3.
  always_comb begin
    st_mask = 4'b0000;
    case (req_q.func3)
      3'b000:  st_mask = 4'b0001 << off;
      3'b001:  st_mask = 4'b0011 << off;
      3'b010:  st_mask = 4'b1111;
      default: st_mask = 4'b0000;
    endcase
  end

  assign st_wdata = req_q.wdata << {off, 3'b000};

  // ---------------- load extraction ----------------
  assign ld_shift = mem_resp_rdata >> {off, 3'b000};

  always_comb begin
    ld_data = 32'h0;
    case (req_q.func3)
      3'b000:  ld_data = {{24{ld_shift[7]}},  ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b010:  ld_data = ld_shift;
      3'b100:  ld_data = {24'h0, ld_shift[7:0]};
      3'b101:  ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = 32'h0;
    endcase
  end

  // ---------------- result register ----------------
  // On accept, the result (or faulting address) is captured; memory ops
  // overwrite it when the response arrives. Stores report 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= 32'h0;
    end else if (accept) begin
      data_q <= fault_in ? 32'(in_addr) : in_result;
    end else if ((state == RESP) && mem_resp_valid) begin
      data_q <= req_q.load ? ld_data : 32'h0;
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        fault_q <= 1'b0;
    else if (accept) fault_q <= fault_in;
  end
  assign out_fault = fault_q;
`else
  assign out_fault = 1'b0;
`endif

  // ---------------- outputs ----------------
  assign in_ready      = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  // Address is allowed to hold the latched value outside REQ.
  assign mem_req_addr  = {req_q.addr[ADDR_W-1:2], 2'b00};
  // Strobes/data only for stores, and only while the request is presented.
  assign mem_req_wen   = (state == REQ) && req_q.store;
  assign mem_req_wmask = ((state == REQ) && req_q.store) ? st_mask  : 4'b0000;
  assign mem_req_wdata = ((state == REQ) && req_q.store) ? st_wdata : 32'h0;
  assign out_valid     = (state == OUT);
  assign out_data      = data_q;

endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
// Testbench for ysyx_24110015_lsu: directed plan cases plus randomized
// transactions with random handshake stalls, checked every cycle against a
// transaction-level model of expected phase and output values.
module tb_ysyx_24110015_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_addr, in_wdata, in_result;
  logic [2:0]  in_func3;
  logic        in_load, in_store;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        out_valid, out_ready, out_fault;
  logic [31:0] out_data;

  ysyx_24110015_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_func3(in_func3), .in_load(in_load),
    .in_store(in_store), .in_result(in_result),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  localparam int PH_RST = 0, PH_IDLE = 1, PH_REQ = 2, PH_RESP = 3, PH_OUT = 4;
  int          phase = PH_RST;
  logic [31:0] exp_addr, exp_wdata, exp_data;
  logic [3:0]  exp_mask;
  logic        exp_wen, exp_fault;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [3:0] m_wmask(input logic [1:0] off, input logic [2:0] f3);
    int m;
    case (f3)
      3'd0: m = 1;
      3'd1: m = 3;
      3'd2: return 4'hF;
      default: return 4'h0;
    endcase
    m = (m << off) % 16;
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] off,
                                         input logic [2:0] f3);
    logic [31:0] sh;
    int unsigned b, h;
    sh = rd >> (8 * off);
    b  = sh % 256;
    h  = sh % 65536;
    case (f3)
      3'd0: return (b >= 128) ? 32'hFFFF_FF00 + b : b;
      3'd1: return (h >= 32768) ? 32'hFFFF_0000 + h : h;
      3'd2: return sh;
      3'd4: return b;
      3'd5: return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_misalign(input logic [31:0] a, input logic [2:0] f3,
                                    input logic ld, input logic st);
`ifdef LSU_MISALIGN_CHECK_EN
    if (!(ld || st)) return 1'b0;
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) return 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (phase == PH_RST) begin
      chk("rst_in_ready",  {31'h0, in_ready},      32'h1);
      chk("rst_req_valid", {31'h0, mem_req_valid}, 32'h0);
      chk("rst_out_valid", {31'h0, out_valid},     32'h0);
      chk("rst_out_data",  out_data,               32'h0);
      chk("rst_out_fault", {31'h0, out_fault},     32'h0);
      chk("rst_wen",       {31'h0, mem_req_wen},   32'h0);
      chk("rst_wmask",     {28'h0, mem_req_wmask}, 32'h0);
    end else begin
      chk("in_ready",  {31'h0, in_ready},      {31'h0, phase == PH_IDLE});
      chk("req_valid", {31'h0, mem_req_valid}, {31'h0, phase == PH_REQ});
      chk("out_valid", {31'h0, out_valid},     {31'h0, phase == PH_OUT});
      if (phase == PH_REQ) begin
        chk("req_addr",  mem_req_addr,           exp_addr);
        chk("req_wen",   {31'h0, mem_req_wen},   {31'h0, exp_wen});
        chk("req_wmask", {28'h0, mem_req_wmask}, {28'h0, exp_mask});
        chk("req_wdata", mem_req_wdata,          exp_wdata);
      end else begin
        chk("idle_wen",   {31'h0, mem_req_wen},   32'h0);
        chk("idle_wmask", {28'h0, mem_req_wmask}, 32'h0);
        chk("idle_wdata", mem_req_wdata,          32'h0);
      end
      if (phase == PH_OUT) begin
        chk("out_data",  out_data,           exp_data);
        chk("out_fault", {31'h0, out_fault}, {31'h0, exp_fault});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random values on the execute inputs while not idle; must not be captured.
  task automatic garble();
    int r;
    r = $urandom_range(0, 2);
    in_addr   = $urandom;
    in_wdata  = $urandom;
    in_func3  = 3'($urandom);
    in_load   = (r == 1);
    in_store  = (r == 2);
    in_result = $urandom;
  endtask

  task automatic do_txn(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                        input logic ld, input logic st, input logic [31:0] res,
                        input logic [31:0] rd, input int rqs, input int rss, input int os,
                        input bit has_lit, input logic [31:0] lit);
    logic [1:0] off;
    bit flt, mem;
    off = a[1:0];
    flt = m_misalign(a, f3, ld, st);
    mem = (ld || st) && !flt;
    exp_addr  = a & 32'hFFFF_FFFC;
    exp_wen   = st;
    exp_mask  = st ? m_wmask(off, f3) : 4'h0;
    exp_wdata = st ? (wd << (8 * off)) : 32'h0;
    exp_fault = flt;
    exp_data  = flt ? a : !(ld || st) ? res : ld ? m_load(rd, off, f3) : 32'h0;
    if (has_lit) exp_data = lit;

    in_valid = 1'b1; in_addr = a; in_wdata = wd; in_func3 = f3;
    in_load = ld; in_store = st; in_result = res;
    mem_resp_valid = 1'($urandom);   // stray response while idle: ignored
    mem_req_ready  = 1'($urandom);
    phase = PH_IDLE;
    step();
    in_valid = 1'($urandom);
    garble();
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
    if (mem) begin
      phase = PH_REQ;
      for (int i = 0; i < rqs; i++) begin step(); garble(); end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      garble();
      phase = PH_RESP;
      for (int i = 0; i < rss; i++) begin mem_resp_rdata = $urandom; step(); garble(); end
      mem_resp_valid = 1'b1;
      mem_resp_rdata = rd;
      step();
      mem_resp_valid = 1'b0;
      mem_resp_rdata = $urandom;
    end
    phase = PH_OUT;
    out_ready = 1'b0;
    for (int i = 0; i < os; i++) begin step(); garble(); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    phase = PH_IDLE;
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_func3 = '0;
    in_load = 1'b0; in_store = 1'b0; in_result = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    out_ready = 1'b0;
    phase = PH_RST;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    phase = PH_IDLE;
    step();

    // Model pins: hand-computed values.
    chk("pin_lb",    m_load(32'h80FF_FFFF, 2'd3, 3'd0), 32'hFFFF_FF80);
    chk("pin_lbu",   m_load(32'h80FF_FFFF, 2'd3, 3'd4), 32'h0000_0080);
    chk("pin_shmsk", {28'h0, m_wmask(2'd2, 3'd1)},      32'h0000_000C);
    chk("pin_sbmsk", {28'h0, m_wmask(2'd3, 3'd0)},      32'h0000_0008);

    // Directed plan cases (literal out_data where given).
    do_txn(32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h1234_5678, 32'h0, 0, 0, 0, 1'b1, 32'h1234_5678);
    do_txn(32'h8000_0003, 32'h0, 3'd0, 1'b1, 1'b0, 32'h0, 32'h80FF_FFFF, 0, 0, 0, 1'b1, 32'hFFFF_FF80);
    do_txn(32'h8000_0003, 32'h0, 3'd4, 1'b1, 1'b0, 32'h0, 32'h80FF_FFFF, 0, 0, 0, 1'b1, 32'h0000_0080);
    do_txn(32'h8000_0002, 32'h0000_ABCD, 3'd1, 1'b0, 1'b1, 32'h5555_5555, 32'h0, 0, 0, 0, 1'b1, 32'h0);
    chk("pin_shdata", exp_wdata, 32'hABCD_0000);
    // Backpressure on all three handshakes.
    do_txn(32'h8000_0101, 32'h0000_00EE, 3'd0, 1'b0, 1'b1, 32'h0, 32'h0, 3, 2, 2, 1'b0, 32'h0);
    do_txn(32'h8000_0102, 32'h0, 3'd5, 1'b1, 1'b0, 32'h0, 32'hBEEF_1234, 3, 2, 2, 1'b0, 32'h0);
    // Misaligned word load.
`ifdef LSU_MISALIGN_CHECK_EN
    do_txn(32'h8000_0002, 32'h0, 3'd2, 1'b1, 1'b0, 32'h0, 32'h1122_3344, 0, 0, 0, 1'b1, 32'h8000_0002);
`else
    do_txn(32'h8000_0002, 32'h0, 3'd2, 1'b1, 1'b0, 32'h0, 32'h1122_3344, 0, 0, 0, 1'b1, 32'h0000_1122);
`endif

    // Reset asserted while waiting for the response.
    in_valid = 1'b1; in_addr = 32'h8000_0010; in_func3 = 3'd2;
    in_load = 1'b1; in_store = 1'b0; in_result = 32'h0;
    exp_addr = 32'h8000_0010; exp_wen = 1'b0; exp_mask = 4'h0; exp_wdata = 32'h0;
    phase = PH_IDLE;
    step();
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    phase = PH_REQ;
    step();
    mem_req_ready = 1'b0;
    phase = PH_RESP;
    step();
    rst = 1'b0;
    phase = PH_RST;
    step();
    rst = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hDEAD_BEEF;
    phase = PH_IDLE;
    step();
    step();
    mem_resp_valid = 1'b0;
    step();

    // Randomized transactions.
    for (int n = 0; n < 250; n++) begin
      int k;
      k = $urandom_range(0, 2);
      do_txn($urandom, $urandom, 3'($urandom), k == 1, k == 2, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 32'h0);
      if ($urandom_range(0, 3) == 0) step();
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24110015_lsu.md
# ysyx_24110015_lsu

Multi-cycle load/store unit placed directly downstream of the execute stage. It takes the execute stage's result (effective address, store data, func3, load/store flags, ALU/CSR result) over a valid/ready handshake. It performs byte-lane alignment and the memory transaction over a request/response bus, replacing the combinational DPI memory access. It then hands the sign- or zero-extended load data, or the passed-through result, to write-back over a second valid/ready handshake.

## Interface
Parameters:
- ADDR_W, 32, address width; only the low 2 bits are used for lane selection.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  LSU can accept; high only in IDLE.
- in_addr  in  ADDR_W  effective address (ALU output).
- in_wdata  in  32  store data (rs2).
- in_func3  in  3  access size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
- in_load  in  1  instruction is a load.
- in_store  in  1  instruction is a store; in_load and in_store are never both 1.
- in_result  in  32  ALU/CSR result for non-memory instructions.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr  out  ADDR_W  word-aligned address (in_addr with [1:0]=0).
- mem_req_wen  out  1  1 = write, 0 = read.
- mem_req_wdata  out  32  lane-shifted store data.
- mem_req_wmask  out  4  byte strobes.
- mem_resp_valid  in  1  response/acknowledge (for both reads and writes).
- mem_resp_rdata  in  32  read word.
- out_valid  out  1  result valid for write-back.
- out_ready  in  1  write-back accepts.
- out_data  out  32  load data, in_result, or 0 for stores.
- out_fault  out  1  misaligned access (see Configuration).

## Operation
- States: IDLE, REQ, RESP, OUT. Reset enters IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch all inputs.
  - If neither load nor store: out_data<=in_result, next OUT.
  - Otherwise: next REQ.
- REQ: mem_req_valid=1 with the latched fields held stable. On mem_req_ready, next RESP.
- RESP: wait for mem_resp_valid, then next OUT.
  - Load: out_data<=extended data.
  - Store: out_data<=0.
- OUT: out_valid=1. On out_ready, next IDLE. out_data and out_fault are held stable until accepted.
- Lane offset is off=addr[1:0].
- Store wmask:
  - sb: 4'b0001<<off.
  - sh: 4'b0011<<off.
  - sw: 4'b1111.
  - Other func3: 4'b0000; the request is still issued.
  - Bits shifted past lane 3 are dropped.
  - wdata = in_wdata<<(8*off).
- Load: sh = rdata>>(8*off), then:
  - 000: sign-extend sh[7:0].
  - 001: sign-extend sh[15:0].
  - 010: sh.
  - 100: zero-extend sh[7:0].
  - 101: zero-extend sh[15:0].
  - Other func3: 0.
- mem_req_* outputs are 0 outside REQ, except mem_req_addr, which may hold the latched value.

## Timing
- Reset values: state IDLE; in_ready=1, mem_req_valid=0, out_valid=0, out_data=0, out_fault=0, mem_req_wen=0, mem_req_wmask=0.
- Reset asserted mid-transaction returns to IDLE immediately with the values above. A later mem_resp_valid in IDLE is ignored.
- Non-memory instruction: accepted at cycle 0, out_valid at cycle 1.
- Memory instruction, minimum latency:
  - Cycle 0: accept.
  - Cycle 1: REQ (ready same cycle).
  - Cycle 2: RESP (resp_valid same cycle).
  - Cycle 3: out_valid.
- Each stall cycle of mem_req_ready, mem_resp_valid or out_ready adds exactly one cycle.
- No new instruction is accepted until the OUT handshake completes (one instruction in flight).
- mem_resp_valid while in REQ is ignored. The memory never responds before accepting the request.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: a halfword access with off[0]=1, or a word access with off!=0, skips REQ/RESP and goes straight to OUT with out_fault=1 and out_data=latched address. No memory request is issued.
- LSU_MISALIGN_CHECK_EN undefined: no check is made and out_fault is tied 0. Misaligned accesses are issued with truncated masks, and loads return the shifted, truncated data.

## Test plan
- Non-memory: in_result=0x1234_5678, out_ready=1 -> out_valid at cycle 1 with out_data=0x1234_5678, no mem_req_valid.
- lb at 0x8000_0003, rdata=0x80FF_FFFF -> mem_req_addr=0x8000_0000, wen=0, out_data=0xFFFF_FF80. Same access as lbu -> 0x0000_0080.
- sh at 0x8000_0002, wdata=0x0000_ABCD -> wmask=4'b1100, mem_req_wdata=0xABCD_0000; after resp, out_data=0.
- Backpressure: mem_req_ready low 3 cycles, resp 2 cycles later, out_ready low 2 cycles -> request fields stable throughout, out_valid stays high with data stable, in_ready=0 until the handshake.
- Reset (rst=0) asserted in RESP -> all outputs at reset values that cycle; a stray mem_resp_valid after release produces no out_valid.
- With LSU_MISALIGN_CHECK_EN: lw at 0x8000_0002 -> no mem_req_valid, out_fault=1, out_data=0x8000_0002 at cycle 1. Without the macro: the request is issued with wmask=0 for loads and out_fault=0.
